uart_transmitter_param: RTL
===========================

# uart_transmitter_param

Parametrised UART transmit framer, the successor to `uart_transmitter_core`. It replaces the external `shift_clk` tick with an internal baud divider. Data width, parity mode and stop-bit count are configurable, and it provides a clean start/busy/finish handshake. It sits between the host-side result logic (recognised-digit output) and the FPGA TX pin.

## Interface
- `DATA_BITS`, default 8: payload width, legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `CLKS_PER_BIT`, default 434: clk cycles per serial bit, ≥ 1.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request; sampled each rising edge.
- `d`  input  DATA_BITS  payload; captured on the accepting edge.
- `bit_out`  output  1  serial line, idle high.
- `busy`  output  1  high while a frame is in progress.
- `finish`  output  1  single-cycle pulse at end of frame.

## Operation
- Reset values: `bit_out`=1, `busy`=0, `finish`=0, state IDLE, all counters 0. Reset mid-frame aborts immediately, and the line returns high asynchronously.
- FSM states: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE.
- **IDLE:** `bit_out`=1.
  - `start`=1 at an edge latches `d` into the shift register, computes the parity bit, sets `busy`, and enters START.
- **START:** `bit_out`=0 for CLKS_PER_BIT cycles.
- **DATA:** shifts out DATA_BITS bits, LSB first. Each bit is held CLKS_PER_BIT cycles. A bit index counter of width clog2(DATA_BITS) counts 0..DATA_BITS-1.
- **PARITY:**
  - Odd mode: `bit_out` = ~^data.
  - Even mode: `bit_out` = ^data.
  - Parity is computed from the latched data, not from live `d`.
- **STOP:** `bit_out`=1 for STOP_BITS×CLKS_PER_BIT cycles.
- Baud counter:
  - Width clog2(CLKS_PER_BIT).
  - Reloads to 0 on every state entry.
  - Advances the bit/state when it reaches CLKS_PER_BIT-1.
- `start` while `busy`=1 is ignored, with no queuing. `d` changes while busy have no effect.
- `start` held high continuously produces back-to-back frames separated by exactly one idle cycle.

## Timing
- Frame bits N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- Accepting edge E0: from the clock cycle after E0, `bit_out`=0 and `busy`=1. Latency from `start` to line low is 1 cycle.
- Frame duration on the line is exactly N×CLKS_PER_BIT cycles after E0.
- At edge E0 + N×CLKS_PER_BIT: state IDLE, `busy`=0, `finish`=1 for exactly one cycle, `bit_out`=1.
- `start` asserted during the `finish` cycle is accepted at the next edge.
- CLKS_PER_BIT=1 is legal: one cycle per bit, no stretching.
- All outputs are registered. `bit_out` comes directly from a flop, so the line is glitch-free.

## Structure
- Shared package `uart_pkg`:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - `clog2` helper function.
  - Both the future receiver and this block use it.
- One sub-module, `uart_baud_counter`:
  - Parameter CLKS_PER_BIT; inputs `clk`, `rst_n`, `clear`.
  - Output `bit_done`, a one-cycle pulse when the count reaches CLKS_PER_BIT-1.
  - Reused by the receiver with a half-bit sampling offset.
- Elaboration-time checks reject DATA_BITS outside 5–9, STOP_BITS outside 1–2, PARITY > 2, and CLKS_PER_BIT < 1.

## Test plan
- **Reset:** rst_n=0 mid-DATA of a frame with CLKS_PER_BIT=4 → `bit_out`=1, `busy`=0 and `finish`=0 immediately without a clock edge. After release, the line stays idle until the next `start`.
- **Basic frame:** DATA_BITS=8, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=4, d=8'hAB, one-cycle `start` pulse → line sequence 0,1,1,0,1,0,1,0,1,1 with each bit 4 cycles. `finish` pulses 40 cycles after the accepting edge.
- **Even parity, two stops:** PARITY=2, STOP_BITS=2, d=8'hAB (popcount 5) → parity bit 1, then 8 stop cycles high. `finish` at 48 cycles.
- **Odd parity, 7-bit:** DATA_BITS=7, PARITY=1, d=7'h00 → 7 zero bits, then parity bit 1. Frame is 10 bits; `finish` at 40 cycles.
- **Busy ignore and back-to-back:**
  - `start` pulse with d=8'h55 during a frame → ignored. Only the first byte appears on the line.
  - `start` held high → second frame's start bit begins exactly 1 cycle after the `finish` pulse.
- **CLKS_PER_BIT=1:** d=8'hF0, no parity → 10-cycle frame 0,0,0,0,0,1,1,1,1,1. `finish` at cycle 10.

Source files
------------

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared UART constants, FSM state encoding and clog2 helper
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_transmitter_param_if.sv
//------------------------------------------------------------------------------
// uart_transmitter_param_if : host-side handshake and serial line bundle
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_transmitter_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] d;
    logic                 bit_out;
    logic                 busy;
    logic                 finish;

    modport master (
        output start,
        output d,
        input  bit_out,
        input  busy,
        input  finish
    );

    modport slave (
        input  start,
        input  d,
        output bit_out,
        output busy,
        output finish
    );
endinterface

`default_nettype wire

// File: rtl/uart_baud_counter.sv
//------------------------------------------------------------------------------
// uart_baud_counter : free-running bit-period counter with synchronous clear
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    // One-cycle-per-bit still needs a 1-bit register to stay well formed
    localparam int              CW   = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        bit_done = (cnt_q == LAST);
        cnt_d    = cnt_q + ONE;
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_transmitter_param.sv
//------------------------------------------------------------------------------
// uart_transmitter_param : parametrised UART transmit framer with baud divider
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_transmitter_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_transmitter_param_if.slave  bus
);

    localparam int            IW        = clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_transmitter_param: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_transmitter_param: STOP_BITS must be 1 or 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_transmitter_param: PARITY must be 0, 1 or 2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
            $error("uart_transmitter_param: CLKS_PER_BIT must be >= 1");
        end
    endgenerate

    uart_state_e          state_q,   state_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [IW-1:0]        idx_q,     idx_d;
    logic                 parity_q,  parity_d;
    logic                 bit_out_q, bit_out_d;
    logic                 busy_q,    busy_d;
    logic                 finish_q,  finish_d;
    logic                 baud_clear;
    logic                 bit_done;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .bit_done (bit_done)
    );

    // Outputs are computed for the next state so every line level comes from a flop
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        parity_d   = parity_q;
        bit_out_d  = bit_out_q;
        busy_d     = busy_q;
        finish_d   = 1'b0;
        baud_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_out_d = 1'b1;
                busy_d    = 1'b0;
                if (bus.start) begin
                    shift_d    = bus.d;
                    parity_d   = (PARITY == PAR_ODD) ? ~^bus.d : ^bus.d;
                    busy_d     = 1'b1;
                    bit_out_d  = 1'b0;
                    baud_clear = 1'b1;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (bit_done) begin
                    idx_d      = '0;
                    bit_out_d  = shift_q[0];
                    baud_clear = 1'b1;
                    state_d    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_done) begin
                    baud_clear = 1'b1;
                    if (idx_q == LAST_DATA) begin
                        idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            bit_out_d = parity_q;
                            state_d   = ST_PARITY;
                        end else begin
                            bit_out_d = 1'b1;
                            state_d   = ST_STOP;
                        end
                    end else begin
                        idx_d     = idx_q + IDX_ONE;
                        shift_d   = shift_q >> 1;
                        bit_out_d = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_done) begin
                    idx_d      = '0;
                    bit_out_d  = 1'b1;
                    baud_clear = 1'b1;
                    state_d    = ST_STOP;
                end
            end

            ST_STOP: begin
                bit_out_d = 1'b1;
                if (bit_done) begin
                    // Second stop bit reuses the wrapping baud counter
                    if (idx_q == LAST_STOP) begin
                        busy_d     = 1'b0;
                        finish_d   = 1'b1;
                        baud_clear = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_out_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            parity_q  <= 1'b0;
            bit_out_q <= 1'b1;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            parity_q  <= parity_d;
            bit_out_q <= bit_out_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
        end
    end

    assign bus.bit_out = bit_out_q;
    assign bus.busy    = busy_q;
    assign bus.finish  = finish_q;

endmodule

`default_nettype wire
